// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I encoder types, opcodes, NOP and immediate-range helper
package rv32i_pkg;
   typedef enum logic [3:0] {
      CLS_RTYPE  = 4'd0,
      CLS_ITYPE  = 4'd1,
      CLS_LOAD   = 4'd2,
      CLS_STORE  = 4'd3,
      CLS_BRANCH = 4'd4,
      CLS_LUI    = 4'd5,
      CLS_AUIPC  = 4'd6,
      CLS_JAL    = 4'd7,
      CLS_JALR   = 4'd8
   } op_class_e;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef struct packed {
      logic [3:0]  op_class;
      logic [2:0]  funct3;
      logic        alt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } op_desc_t;
   // true when v survives truncation to a bits-wide signed field
   function automatic logic fits_signed(input logic [31:0] v, input int bits);
      logic [31:0] s;
      s = $signed(v) >>> (bits - 1);
      return s == '0 || s == '1;
   endfunction
endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// rv32i_instr_encoder_if: descriptor handshake, flush and instruction-memory write port
interface rv32i_instr_encoder_if #(parameter int ADDR_W = 12);
   logic              i_op_valid;
   logic              o_op_ready;
   logic [3:0]        i_op_class;
   logic [2:0]        i_funct3;
   logic              i_alt;
   logic [4:0]        i_rd;
   logic [4:0]        i_rs1;
   logic [4:0]        i_rs2;
   logic [31:0]       i_imm;
   logic              i_flush;
   logic              o_wr_valid;
   logic              i_wr_ready;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [31:0]       o_wr_data;
   logic              o_err;
   modport slave (
      input  i_op_valid, i_op_class, i_funct3, i_alt, i_rd, i_rs1, i_rs2, i_imm, i_flush, i_wr_ready,
      output o_op_ready, o_wr_valid, o_wr_addr, o_wr_data, o_err
   );
   modport master (
      output i_op_valid, i_op_class, i_funct3, i_alt, i_rd, i_rs1, i_rs2, i_imm, i_flush, i_wr_ready,
      input  o_op_ready, o_wr_valid, o_wr_addr, o_wr_data, o_err
   );
endinterface

// File: rtl/rv32i_field_pack.sv
// rv32i_field_pack: combinational RV32I field packing of one descriptor
// RV32I_ENC_ILLEGAL_CHECK_EN: replace unrepresentable descriptors with NOP and flag err.
module rv32i_field_pack
   import rv32i_pkg::*;
(
   input  logic [3:0]  op_class,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        err
);
   logic [6:0] f7;
   logic       shift;
   logic       bad;
   assign f7 = alt ? 7'b0100000 : 7'b0;
   assign shift = funct3[1:0] == 2'b01;
`ifdef RV32I_ENC_ILLEGAL_CHECK_EN
   always_comb begin
      bad = 1'b0;
      case (op_class)
         CLS_RTYPE:         bad = alt && funct3 != 3'b000 && funct3 != 3'b101;
         CLS_ITYPE:         bad = (alt && funct3 != 3'b101) || (shift ? imm[31:5] != '0 : !fits_signed(imm, 12));
         CLS_LOAD:          bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || !fits_signed(imm, 12);
         CLS_STORE:         bad = funct3 > 3'b010 || !fits_signed(imm, 12);
         CLS_BRANCH:        bad = funct3[2:1] == 2'b01 || !fits_signed(imm, 13) || imm[0];
         CLS_LUI, CLS_AUIPC: bad = imm[11:0] != '0;
         CLS_JAL:           bad = !fits_signed(imm, 21) || imm[0];
         CLS_JALR:          bad = funct3 != 3'b000 || !fits_signed(imm, 12);
         default:           bad = 1'b0;
      endcase
   end
`else
   assign bad = 1'b0;
`endif
   always_comb begin
      instr = NOP;
      err = 1'b0;
      case (op_class)
         CLS_RTYPE:  instr = {f7, rs2, rs1, funct3, rd, OPC_RTYPE};
         CLS_ITYPE:  instr = shift ? {f7, imm[4:0], rs1, funct3, rd, OPC_ITYPE} : {imm[11:0], rs1, funct3, rd, OPC_ITYPE};
         CLS_LOAD:   instr = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
         CLS_STORE:  instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
         CLS_BRANCH: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
         CLS_LUI:    instr = {imm[31:12], rd, OPC_LUI};
         CLS_AUIPC:  instr = {imm[31:12], rd, OPC_AUIPC};
         CLS_JAL:    instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         CLS_JALR:   instr = {imm[11:0], rs1, funct3, rd, OPC_JALR};
         default:    err = 1'b1;
      endcase
      if (bad) begin
         instr = NOP;
         err = 1'b1;
      end
   end
endmodule

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: 2-stage valid/ready RV32I encoder feeding an instruction-memory write port
// RV32I_ENC_ILLEGAL_CHECK_EN enables illegal-descriptor rejection inside rv32i_field_pack.
module rv32i_instr_encoder
   import rv32i_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int BASE_ADDR = 0
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   rv32i_instr_encoder_if.slave bus
);
   op_desc_t    s1;
   logic        s1_valid;
   logic        adv;
   logic        op_hs;
   logic        pack_err;
   logic [31:0] pack_instr;
   assign adv = !bus.o_wr_valid || bus.i_wr_ready;
   assign bus.o_op_ready = i_rst_n && !bus.i_flush && (!s1_valid || adv);
   assign op_hs = bus.i_op_valid && bus.o_op_ready;
   rv32i_field_pack u_pack (
      .op_class (s1.op_class),
      .funct3   (s1.funct3),
      .alt      (s1.alt),
      .rd       (s1.rd),
      .rs1      (s1.rs1),
      .rs2      (s1.rs2),
      .imm      (s1.imm),
      .instr    (pack_instr),
      .err      (pack_err)
   );
   // o_wr_addr doubles as the write pointer: it only moves on a write handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1 <= '0;
         s1_valid <= 1'b0;
         bus.o_wr_valid <= 1'b0;
         bus.o_wr_data <= '0;
         bus.o_wr_addr <= ADDR_W'(BASE_ADDR);
         bus.o_err <= 1'b0;
      end else if (bus.i_flush) begin
         s1_valid <= 1'b0;
         bus.o_wr_valid <= 1'b0;
         bus.o_wr_addr <= ADDR_W'(BASE_ADDR);
         bus.o_err <= 1'b0;
      end else begin
         if (op_hs) begin
            s1 <= {bus.i_op_class, bus.i_funct3, bus.i_alt, bus.i_rd, bus.i_rs1, bus.i_rs2, bus.i_imm};
            s1_valid <= 1'b1;
         end else if (adv) begin
            s1_valid <= 1'b0;
         end
         if (adv) bus.o_wr_valid <= s1_valid;
         if (adv && s1_valid) begin
            bus.o_wr_data <= pack_instr;
            bus.o_err <= bus.o_err || pack_err;
         end
         if (bus.o_wr_valid && bus.i_wr_ready) bus.o_wr_addr <= bus.o_wr_addr + 1'b1;
      end
   end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: scoreboard bench with directed vectors and randomized descriptors
module tb_rv32i_instr_encoder;
   import rv32i_pkg::*;
   localparam int AW = 2;
   localparam int BASE = 0;
   typedef struct {
      int unsigned cls, f3, rd, rs1, rs2;
      bit          alt;
      logic [31:0] imm;
   } op_t;
   typedef struct {
      logic [31:0] w;
      bit          e;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   int exp_addr = BASE;
   bit sticky = 1'b0;
   rv32i_instr_encoder_if #(.ADDR_W(AW)) bus ();
   rv32i_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic op_t mk(int unsigned cls, int unsigned f3, bit alt, int unsigned rd,
                              int unsigned rs1, int unsigned rs2, logic [31:0] imm);
      op_t o;
      o.cls = cls; o.f3 = f3; o.alt = alt; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
      return o;
   endfunction
   // reference encoder: fields placed by arithmetic from the RV32I format tables
   function automatic exp_t model(int unsigned cls, int unsigned f3, bit alt, int unsigned rd,
                                  int unsigned rs1, int unsigned rs2, logic [31:0] imm);
      exp_t r;
      int unsigned u, w, f7;
      bit sh, bad;
      u = imm;
      sh = (f3 == 1 || f3 == 5);
      f7 = alt ? 32 : 0;
      bad = 1'b0;
      w = 0;
      case (cls)
         CLS_RTYPE:  w = 51 | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
         CLS_ITYPE:  w = 19 | rd << 7 | f3 << 12 | rs1 << 15 | (sh ? ((u % 32) << 20 | f7 << 25) : (u % 4096) << 20);
         CLS_LOAD:   w = 3 | rd << 7 | f3 << 12 | rs1 << 15 | (u % 4096) << 20;
         CLS_STORE:  w = 35 | (u % 32) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((u / 32) % 128) << 25;
         CLS_BRANCH: w = 99 | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | f3 << 12 | rs1 << 15 | rs2 << 20
                         | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
         CLS_LUI:    w = 55 | rd << 7 | (u & 32'hFFFFF000);
         CLS_AUIPC:  w = 23 | rd << 7 | (u & 32'hFFFFF000);
         CLS_JAL:    w = 111 | rd << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20 | ((u >> 1) & 1023) << 21
                         | ((u >> 20) & 1) << 31;
         CLS_JALR:   w = 103 | rd << 7 | f3 << 12 | rs1 << 15 | (u % 4096) << 20;
         default:    bad = 1'b1;
      endcase
`ifdef RV32I_ENC_ILLEGAL_CHECK_EN
      begin
         int v;
         bit i12, b13, j21;
         v = $signed(imm);
         i12 = v >= -2048 && v <= 2047;
         b13 = v >= -4096 && v <= 4095 && u % 2 == 0;
         j21 = v >= -(1 << 20) && v < (1 << 20) && u % 2 == 0;
         case (cls)
            CLS_RTYPE:  bad = alt && f3 != 0 && f3 != 5;
            CLS_ITYPE:  bad = (alt && f3 != 5) || (sh ? u > 31 : !i12);
            CLS_LOAD:   bad = f3 == 3 || f3 >= 6 || !i12;
            CLS_STORE:  bad = f3 > 2 || !i12;
            CLS_BRANCH: bad = f3 == 2 || f3 == 3 || !b13;
            CLS_LUI, CLS_AUIPC: bad = u % 4096 != 0;
            CLS_JAL:    bad = !j21;
            CLS_JALR:   bad = f3 != 0 || !i12;
            default:    bad = 1'b1;
         endcase
      end
`endif
      r.w = bad ? 32'h13 : w;
      r.e = bad;
      return r;
   endfunction
   function automatic op_t rand_op();
      op_t o;
      int m;
      logic [31:0] r;
      o.cls = $urandom_range(0, 10);
      if (o.cls > 8) o.cls = $urandom_range(9, 15);
      o.f3 = $urandom_range(0, 7);
      o.alt = $urandom_range(0, 3) == 0;
      o.rd = $urandom_range(0, 31);
      o.rs1 = $urandom_range(0, 31);
      o.rs2 = $urandom_range(0, 31);
      m = $urandom_range(0, 4);
      r = $urandom;
      o.imm = m == 0 ? 32'($urandom_range(0, 4095)) - 32'd2048 :
              m == 1 ? r :
              m == 2 ? (r & 32'hFFFFF000) :
              m == 3 ? 32'($urandom_range(0, 31)) : {{19{r[12]}}, r[12:1], 1'b0};
      return o;
   endfunction
   task automatic drive(input op_t o);
      bus.i_op_class = 4'(o.cls);
      bus.i_funct3 = 3'(o.f3);
      bus.i_alt = o.alt;
      bus.i_rd = 5'(o.rd);
      bus.i_rs1 = 5'(o.rs1);
      bus.i_rs2 = 5'(o.rs2);
      bus.i_imm = o.imm;
   endtask
   // expects to start at posedge+1 and returns at posedge+1 just after acceptance
   task automatic send(input op_t o);
      drive(o);
      bus.i_op_valid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (bus.o_op_ready) break;
         if (n > 200) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      bus.i_op_valid = 1'b0;
   endtask
   task automatic send_expect(input string name, input op_t o, input logic [31:0] word,
                              input int addr, input bit e);
      send(o);
      @(negedge clk);
      @(negedge clk);
      chk({name, "_valid"}, 32'(bus.o_wr_valid), 32'd1);
      chk({name, "_data"}, bus.o_wr_data, word);
      chk({name, "_addr"}, 32'(bus.o_wr_addr), 32'(addr));
      chk({name, "_err"}, 32'(bus.o_err), 32'(e));
      @(posedge clk); #1;
   endtask
   task automatic do_flush();
      bus.i_flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", 32'(bus.o_op_ready), 32'd0);
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(bus.o_wr_valid), 32'd0);
      chk("flush_err", 32'(bus.o_err), 32'd0);
      chk("flush_addr", 32'(bus.o_wr_addr), 32'(BASE));
      @(posedge clk); #1;
   endtask
   task automatic drain();
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.o_wr_valid) break;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask
   always @(negedge clk)
      if (rst_n && bus.i_op_valid && bus.o_op_ready)
         sb.push_back(model(int'(bus.i_op_class), int'(bus.i_funct3), bus.i_alt, int'(bus.i_rd),
                            int'(bus.i_rs1), int'(bus.i_rs2), bus.i_imm));
   always @(negedge clk) begin
      if (!rst_n || bus.i_flush) begin
         sb.delete();
         exp_addr = BASE;
         sticky = 1'b0;
      end else if (bus.o_wr_valid) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_write", 32'(bus.o_wr_valid), 32'd0);
         end else begin
            chk("sb_data", bus.o_wr_data, sb[0].w);
            chk("sb_addr", 32'(bus.o_wr_addr), 32'(exp_addr));
            chk("sb_err", 32'(bus.o_err), 32'(sticky | sb[0].e));
            if (bus.i_wr_ready) begin
               sticky |= sb[0].e;
               void'(sb.pop_front());
               exp_addr = (exp_addr + 1) % (1 << AW);
            end
         end
      end
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      op_t add, sub, bp[3];
      int idx, wrote;
      bit acc;
      add = mk(CLS_RTYPE, 0, 0, 3, 1, 2, 0);
      sub = mk(CLS_RTYPE, 0, 1, 3, 1, 2, 0);
      bus.i_op_valid = 0; bus.i_flush = 0; bus.i_wr_ready = 0;
      drive(add);
      #1 rst_n = 1'b0;
      #2;
      chk("rst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
      chk("rst_op_ready", 32'(bus.o_op_ready), 32'd0);
      chk("rst_err", 32'(bus.o_err), 32'd0);
      chk("rst_data", bus.o_wr_data, 32'd0);
      chk("rst_addr", 32'(bus.o_wr_addr), 32'(BASE));
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_op_ready", 32'(bus.o_op_ready), 32'd1);
      @(posedge clk); #1;
      bus.i_wr_ready = 1'b1;
      send(add);
      send(sub);
      @(negedge clk);
      chk("add_valid", 32'(bus.o_wr_valid), 32'd1);
      chk("add_data", bus.o_wr_data, 32'h002081B3);
      chk("add_addr", 32'(bus.o_wr_addr), 32'd0);
      @(negedge clk);
      chk("sub_valid", 32'(bus.o_wr_valid), 32'd1);
      chk("sub_data", bus.o_wr_data, 32'h402081B3);
      chk("sub_addr", 32'(bus.o_wr_addr), 32'd1);
      @(posedge clk); #1;
      send_expect("addi", mk(CLS_ITYPE, 0, 0, 1, 0, 0, 32'hFFFFFFFF), 32'hFFF00093, 2, 0);
      send_expect("beq", mk(CLS_BRANCH, 0, 0, 0, 1, 2, 32'd8), 32'h00208463, 3, 0);
      send_expect("jal", mk(CLS_JAL, 0, 0, 1, 0, 0, 32'd2048), 32'h001000EF, 0, 0);
      send_expect("lui", mk(CLS_LUI, 0, 0, 5, 0, 0, 32'h12345000), 32'h123452B7, 1, 0);
`ifdef RV32I_ENC_ILLEGAL_CHECK_EN
      send_expect("ill", mk(CLS_ITYPE, 0, 0, 1, 0, 0, 32'h800), 32'h00000013, 2, 1);
`else
      send_expect("ill", mk(CLS_ITYPE, 0, 0, 1, 0, 0, 32'h800), 32'h80000093, 2, 0);
`endif
      do_flush();
      for (int i = 0; i < 5; i++) send(rand_op());
      drain();
      chk("wrap_addr", 32'(bus.o_wr_addr), 32'd1);
      send_expect("unknown", mk(15, 0, 0, 1, 1, 1, 32'd5), 32'h00000013, 1, 1);
      bus.i_wr_ready = 1'b0;
      send(add);
      @(negedge clk);
      @(negedge clk);
      chk("pend_valid", 32'(bus.o_wr_valid), 32'd1);
      @(posedge clk); #1;
      bus.i_flush = 1'b1;
      bus.i_wr_ready = 1'b1;
      @(negedge clk);
      chk("pflush_ready", 32'(bus.o_op_ready), 32'd0);
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      @(negedge clk);
      chk("pflush_valid", 32'(bus.o_wr_valid), 32'd0);
      chk("pflush_err", 32'(bus.o_err), 32'd0);
      chk("pflush_addr", 32'(bus.o_wr_addr), 32'd0);
      @(posedge clk); #1;
      send_expect("post_flush", add, 32'h002081B3, 0, 0);
      do_flush();
      bp[0] = add; bp[1] = sub; bp[2] = mk(CLS_ITYPE, 0, 0, 1, 0, 0, 32'hFFFFFFFF);
      idx = 0; wrote = 0;
      bus.i_wr_ready = 1'b0;
      drive(bp[0]);
      bus.i_op_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && wrote < 3; cyc++) begin
         @(negedge clk);
         if (cyc == 5) begin
            chk("bp_accepted", 32'(idx), 32'd2);
            chk("bp_ready", 32'(bus.o_op_ready), 32'd0);
            chk("bp_valid", 32'(bus.o_wr_valid), 32'd1);
            chk("bp_data", bus.o_wr_data, 32'h002081B3);
         end
         if (bus.i_op_valid && bus.o_op_ready) idx++;
         if (bus.o_wr_valid && bus.i_wr_ready) begin
            chk("bp_addr", 32'(bus.o_wr_addr), 32'(wrote));
            wrote++;
         end
         @(posedge clk); #1;
         if (idx < 3) drive(bp[idx]);
         else bus.i_op_valid = 1'b0;
         if (cyc == 5) bus.i_wr_ready = 1'b1;
      end
      bus.i_op_valid = 1'b0;
      chk("bp_writes", 32'(wrote), 32'd3);
      bus.i_wr_ready = 1'b0;
      send(add);
      @(negedge clk);
      @(negedge clk);
      chk("mid_pre_valid", 32'(bus.o_wr_valid), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_wr_valid", 32'(bus.o_wr_valid), 32'd0);
      chk("mid_op_ready", 32'(bus.o_op_ready), 32'd0);
      chk("mid_data", bus.o_wr_data, 32'd0);
      chk("mid_addr", 32'(bus.o_wr_addr), 32'(BASE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", 32'(bus.o_op_ready), 32'd1);
      @(posedge clk); #1;
      bus.i_wr_ready = 1'b1;
      send_expect("mid_first", sub, 32'h402081B3, BASE, 0);
      begin
         int sent;
         sent = 0;
         for (int cyc = 0; cyc < 20000 && sent < 400; cyc++) begin
            @(negedge clk);
            acc = bus.i_op_valid && bus.o_op_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            bus.i_flush = $urandom_range(0, 59) == 0;
            bus.i_wr_ready = $urandom_range(0, 3) != 0;
            if (acc) bus.i_op_valid = 1'b0;
            if (!bus.i_op_valid && $urandom_range(0, 4) != 0) begin
               drive(rand_op());
               bus.i_op_valid = 1'b1;
            end
         end
         chk("rand_sent", 32'(sent), 32'd400);
      end
      bus.i_flush = 1'b0;
      bus.i_op_valid = 1'b0;
      bus.i_wr_ready = 1'b1;
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv32i_instr_encoder.md
RV32I_INSTR_ENCODER -- requirements
Module: rv32i_instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the instruction-memory write port.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first write word address after reset or flush.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have i_op_valid in 1 and o_op_ready out 1, the descriptor handshake.
REQ-006 SHALL have i_op_class in 4, the instruction format class: RTYPE, ITYPE, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR; all other codes are unknown.
REQ-007 SHALL have i_funct3 in 3; i_alt in 1 (selects SUB/SRA, funct7[5]); i_rd, i_rs1 and i_rs2 in 5 each; i_imm in 32, the signed byte immediate.
REQ-008 SHALL have i_flush in 1, which clears the pipeline and rewinds the address.
REQ-009 SHALL have o_wr_valid out 1 and i_wr_ready in 1, the write handshake.
REQ-010 SHALL have o_wr_addr out ADDR_W, o_wr_data out 32 and o_err out 1 (sticky error).

Function
REQ-011 SHALL be a 2-stage valid/ready pipeline: S1 registers the descriptor; S2 registers the encoded word and its address.
REQ-012 SHALL give a latency of 2 edges from handshake to o_wr_valid when there is no backpressure, with throughput of 1 word per cycle.
REQ-013 SHALL assert o_op_ready = !S1.valid | S1-advances; S1 advances when !o_wr_valid | i_wr_ready.
REQ-014 SHALL keep o_wr_addr and o_wr_data stable while o_wr_valid & !i_wr_ready.
REQ-015 SHALL increment the address by 1 on each write handshake, wrapping from 2^ADDR_W-1 to 0.
REQ-016 SHALL encode each class with its standard RV32I opcode and field placement:
- I/S-type: imm[11:0].
- B-type: imm[12:1].
- J-type: imm[20:1].
- LUI/AUIPC: instr[31:12] = i_imm[31:12].
- RTYPE funct7: 0100000 if i_alt, else 0.
- ITYPE funct3 001/101: instr[24:20] = imm[4:0]; funct7 = i_alt ? 0100000 : 0.
REQ-017 SHALL ignore unused register fields for a format (write them as zero).
REQ-018 SHALL, for an unknown class, emit NOP 0x00000013 and set o_err.
REQ-019 SHALL, on i_flush, clear S1/S2 valid, set the next address to BASE_ADDR and clear o_err at the next edge; o_op_ready SHALL be 0 during flush.
REQ-020 SHALL give flush priority over a simultaneous op or write handshake, and the address SHALL still go to BASE_ADDR.
REQ-021 SHALL keep o_err set until flush or reset once it is set.

Reset
REQ-022 SHALL, while i_rst_n = 0, drive o_wr_valid 0, o_op_ready 0, o_err 0, o_wr_data 0 and o_wr_addr BASE_ADDR, with S1 empty.
REQ-023 SHALL assert o_op_ready in the first cycle after reset release; a reset mid-stream SHALL discard all in-flight words.

Configuration
REQ-024 SHALL support macro RV32I_ENC_ILLEGAL_CHECK_EN.
- Defined: the following descriptors SHALL be illegal; each is emitted as 0x00000013 and sets o_err.
  - Immediate not representable in its format: I/S 12-bit signed; B 13-bit signed, even; J 21-bit signed, even; shift imm[31:5] != 0; LUI/AUIPC imm[11:0] != 0.
  - RTYPE i_alt with funct3 not 000/101; ITYPE i_alt with funct3 != 101.
  - LOAD funct3 011/110/111; STORE funct3 > 010; BRANCH funct3 010/011; JALR funct3 != 000.
- Undefined: fields SHALL be truncated without checking, and o_err SHALL be set only for an unknown class.

Structure
REQ-025 SHALL take the class enum, the opcode constants and the NOP constant from the shared package rv32i_pkg.
REQ-026 SHALL put field packing in a combinational sub-module rv32i_field_pack between S1 and S2.

Verification
REQ-027 SHALL cover an ADD/SUB back-to-back stream: RTYPE f3=000 rd3 rs1=1 rs2=2 with alt 0 then 1 -> 0x002081B3 at addr 0, then 0x402081B3 at addr 1, on consecutive cycles.
REQ-028 SHALL cover immediate formats:
- ADDI x1,x0,-1 -> 0xFFF00093.
- BEQ x1,x2,+8 -> 0x00208463.
- JAL x1,+2048 -> 0x001000EF.
- LUI x5,0x12345000 -> 0x123452B7.
REQ-029 SHALL cover backpressure: i_wr_ready=0 with 3 ops offered -> 2 accepted, o_op_ready=0, data stable; on release, 3 writes at addrs 0,1,2.
REQ-030 SHALL cover the illegal check: ADDI rd1 imm=0x800 -> with macro 0x00000013 and o_err=1; without macro 0x80000093 and o_err=0.
REQ-031 SHALL cover flush and wrap: ADDR_W=2 with 5 writes -> addrs 0,1,2,3,0; then flush with a write pending -> no write, next write at addr 0, o_err=0.
REQ-032 SHALL cover reset mid-stream: i_rst_n low with S2 valid -> o_wr_valid=0 immediately, and after release the first word goes to BASE_ADDR.
